t64_cag_mul_sched: RTL

Round-robin scheduler that shares one signed-8 × unsigned-9 multiplier between NUM_REQ requesters in the CAG444→RGB888 custom-instruction datapath, e.g. the three per-channel coefficient products of a pixel. It arbitrates requests, registers operands, computes the 17-bit product and returns it tagged with the requester ID. Responses use a valid/ready handshake with full backpressure. It sits between the CVXIF instruction decode/issue logic and the colour-conversion adders.

---
 rtl/t64_cag_pkg.sv | 13 +
 rtl/t64_cag_mul_core.sv | 21 ++
 rtl/t64_cag_rr_arb.sv | 50 +++++
 rtl/t64_cag_mul_sched.sv | 136 +++++++++++++
 4 files changed

// File: rtl/t64_cag_pkg.sv
// Shared constants for the CAG444->RGB888 custom-instruction datapath.
package t64_cag_pkg;

    // Operand A: signed coefficient
    localparam int A_W         = 8;
    // Operand B: unsigned channel value
    localparam int B_W         = 9;
    // Exact signed product width
    localparam int P_W         = 17;
    // Default number of requesters sharing the multiplier
    localparam int NUM_REQ_DEF = 3;

endpackage : t64_cag_pkg

// File: rtl/t64_cag_mul_core.sv
// Combinational 8-bit signed x 9-bit unsigned multiplier with an exact
// 17-bit signed product (range -65408..64897, never overflows).
module t64_cag_mul_core
    import t64_cag_pkg::*;
(
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p
);

    logic signed [P_W-1:0] a_ext_s;
    logic signed [P_W-1:0] b_ext_s;

    // Extend both operands to the product width so the multiply is exact
    always_comb begin
        a_ext_s = {{(P_W - A_W){a[A_W-1]}}, a};
        b_ext_s = {{(P_W - B_W){1'b0}}, b};
        p       = a_ext_s * b_ext_s;
    end

endmodule : t64_cag_mul_core

// File: rtl/t64_cag_rr_arb.sv
// Round-robin arbiter: searches upward from ptr (mod NUM_REQ) for the first
// active request. It returns a one-hot grant, gated by en, and the pointer
// value to use after this cycle.
module t64_cag_rr_arb #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    next_ptr
);

    logic [NUM_REQ-1:0] grant_raw_s;
    logic [ID_W-1:0]    win_idx_s;
    logic               found_s;

    // Priority search starting at ptr; the first active request wins
    always_comb begin
        logic [ID_W-1:0] idx_v;
        logic            hit_v;
        grant_raw_s = '0;
        win_idx_s   = '0;
        found_s     = 1'b0;
        idx_v       = '0;
        hit_v       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v              = ID_W'((int'(ptr) + k) % NUM_REQ);
            hit_v              = ~found_s & req[idx_v];
            grant_raw_s[idx_v] = hit_v;
            win_idx_s          = hit_v ? idx_v : win_idx_s;
            found_s            = found_s | hit_v;
        end
    end

    // Grant only when the consumer can take an operand; pointer moves past the winner
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        if (en && found_s) begin
            grant    = grant_raw_s;
            next_ptr = ID_W'((int'(win_idx_s) + 1) % NUM_REQ);
        end else begin
            grant    = '0;
            next_ptr = ptr;
        end
    end

endmodule : t64_cag_rr_arb

// File: rtl/t64_cag_mul_sched.sv
// Shares one signed x unsigned multiplier among NUM_REQ requesters.
// Two-stage pipeline (operand register S1, product register S2) with a
// round-robin front end and a valid/ready response port that supports full
// backpressure and one product per cycle.
module t64_cag_mul_sched
    import t64_cag_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [P_W-1:0]         rsp_data
);

    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    next_ptr_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               arb_en_s;

    logic [A_W-1:0]     sel_a_s;
    logic [B_W-1:0]     sel_b_s;
    logic [ID_W-1:0]    sel_id_s;

    logic               s1_valid_r;
    logic [A_W-1:0]     s1_a_r;
    logic [B_W-1:0]     s1_b_r;
    logic [ID_W-1:0]    s1_id_r;

    logic               s2_valid_r;
    logic [P_W-1:0]     s2_data_r;
    logic [ID_W-1:0]    s2_id_r;

    logic [P_W-1:0]     prod_s;
    logic               s2_adv_s;
    logic               can_accept_s;
    logic               accept_s;

    // Pipeline advance conditions; S1 may refill in the same cycle it drains
    always_comb begin
        s2_adv_s     = s1_valid_r & (~s2_valid_r | rsp_ready);
        can_accept_s = ~s1_valid_r | s2_adv_s;
        arb_en_s     = can_accept_s & ap_rst_n;
        req_ready    = grant_s;
        accept_s     = |grant_s;
    end

    t64_cag_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr_r),
        .en       (arb_en_s),
        .grant    (grant_s),
        .next_ptr (next_ptr_s)
    );

    // One-hot operand/ID select of the granted requester
    always_comb begin
        sel_a_s  = '0;
        sel_b_s  = '0;
        sel_id_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s  = sel_a_s  | (req_a[i*A_W +: A_W] & {A_W{grant_s[i]}});
            sel_b_s  = sel_b_s  | (req_b[i*B_W +: B_W] & {B_W{grant_s[i]}});
            sel_id_s = sel_id_s | (ID_W'(i) & {ID_W{grant_s[i]}});
        end
    end

    // Round-robin pointer; the arbiter returns the current value when nothing is accepted
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= next_ptr_s;
        end
    end

    // S1 operand register: load on accept, empty when its content moves to S2
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_id_r    <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= sel_a_s;
            s1_b_r     <= sel_b_s;
            s1_id_r    <= sel_id_s;
        end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    t64_cag_mul_core u_mul (
        .a (s1_a_r),
        .b (s1_b_r),
        .p (prod_s)
    );

    // S2 product register: held stable while the consumer stalls
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
            s2_id_r    <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= 1'b1;
            s2_data_r  <= prod_s;
            s2_id_r    <= s1_id_r;
        end else if (rsp_ready) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Response port is driven straight from the S2 register
    always_comb begin
        rsp_valid = s2_valid_r;
        rsp_id    = s2_id_r;
        rsp_data  = s2_data_r;
    end

endmodule : t64_cag_mul_sched
